// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - LCD timing defaults, scan FSM states, RGB565 field slices, test-bar colours
package lcd_timing_pkg;

    localparam int H_ACTIVE_DEF     = 480;
    localparam int H_FP_DEF         = 8;
    localparam int H_SYNC_DEF       = 4;
    localparam int H_BP_DEF         = 39;
    localparam int V_ACTIVE_DEF     = 272;
    localparam int V_FP_DEF         = 4;
    localparam int V_SYNC_DEF       = 4;
    localparam int V_BP_DEF         = 12;
    localparam int SYNC_ACT_LOW_DEF = 1;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_COLOUR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        return BAR_COLOUR[idx];
    endfunction

endpackage

// File: rtl/lcd_scan_counter.sv
// rtl/lcd_scan_counter.sv - horizontal/vertical scan counters with wrap and region decode
module lcd_scan_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [8:0] h_pos,
    output logic [8:0] v_pos,
    output logic       visible,
    output logic       hsync_act,
    output logic       vsync_act,
    output logic       at_origin,
    output logic       frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;

    always_comb begin
        h_last  = (h_cnt_q == H_LAST);
        v_last  = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_last) begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + CNT_ONE;
        end else begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // VSYNC decodes from the line count alone, so its edges fall on h = 0.
    assign h_pos      = h_cnt_q[8:0];
    assign v_pos      = v_cnt_q[8:0];
    assign visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hsync_act  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vsync_act  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_last = h_last && v_last;

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - 480x272 RGB565 LCD timing generator; LCD_TESTPAT_EN adds colour-bar test pattern
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_FP         = H_FP_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BP         = H_BP_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_FP         = V_FP_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BP         = V_BP_DEF,
    parameter int SYNC_ACT_LOW = SYNC_ACT_LOW_DEF
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        en,
    input  logic [15:0] pix_rgb,
    input  logic        test_mode,
    output logic        pix_req,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        busy,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic        LCD_DEN,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B
);

    localparam logic SYNC_IDLE = (SYNC_ACT_LOW != 0);

    scan_state_e state_q, state_d;
    logic        busy_q, busy_d;

    logic       pix_req_q, pix_req_d;
    logic [8:0] pix_x_q, pix_x_d;
    logic [8:0] pix_y_q, pix_y_d;
    logic       frame_start_q, frame_start_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;

    logic        den_q, den_d;
    logic [15:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    logic       scanning;
    logic [8:0] h_pos, v_pos;
    logic       visible, hsync_act, vsync_act, at_origin, frame_last;
    logic       use_bar;

    assign scanning = (state_q != IDLE);

    lcd_scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_scan (
        .clk        (PixelClk),
        .rst_n      (nRST),
        .run        (scanning),
        .h_pos      (h_pos),
        .v_pos      (v_pos),
        .visible    (visible),
        .hsync_act  (hsync_act),
        .vsync_act  (vsync_act),
        .at_origin  (at_origin),
        .frame_last (frame_last)
    );

`ifdef LCD_TESTPAT_EN
    assign use_bar = test_mode;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign use_bar          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)              state_d = RUN;
                else if (frame_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);

        pix_req_d     = scanning && visible;
        pix_x_d       = pix_req_d ? h_pos : '0;
        pix_y_d       = pix_req_d ? v_pos : '0;
        frame_start_d = at_origin && (state_q == RUN);
        hs1_d         = scanning && hsync_act;
        vs1_d         = scanning && vsync_act;

        // The source answers combinationally from pix_x/pix_y; the pin register is the one-cycle latency.
        den_d   = pix_req_q;
        rgb_d   = '0;
        if (pix_req_q) begin
            rgb_d = use_bar ? bar_colour(pix_x_q[8:6]) : pix_rgb;
        end
        hsync_d = hs1_q ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_d = vs1_q ? ~SYNC_IDLE : SYNC_IDLE;
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            pix_req_q     <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            den_q         <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            pix_req_q     <= pix_req_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            den_q         <= den_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign busy        = busy_q;
    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign LCD_DEN     = den_q;
    assign LCD_HSYNC   = hsync_q;
    assign LCD_VSYNC   = vsync_q;
    assign LCD_R       = rgb_q[R_MSB:R_LSB];
    assign LCD_G       = rgb_q[G_MSB:G_LSB];
    assign LCD_B       = rgb_q[B_MSB:B_LSB];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - vector table plus pixel scoreboard for lcd_timing_gen (short vertical timing)
module tb_lcd_timing_gen;

    localparam int HA = 480;
    localparam int HF = 8;
    localparam int HS = 4;
    localparam int HB = 39;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 6;
    localparam int VF = 3;
    localparam int VS = 4;
    localparam int VB = 2;
    localparam int VT = VA + VF + VS + VB;
    localparam int FP = HT * VT;
`ifdef LCD_TESTPAT_EN
    localparam bit BAR_EN = 1'b1;
`else
    localparam bit BAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRST, en, test_mode;
    logic [15:0] pix_rgb;
    logic        pix_req, frame_start, busy, LCD_HSYNC, LCD_VSYNC, LCD_DEN;
    logic [8:0]  pix_x, pix_y;
    logic [4:0]  LCD_R, LCD_B;
    logic [5:0]  LCD_G;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACT_LOW(1)
    ) dut (
        .PixelClk(clk), .nRST(nRST), .en(en), .pix_rgb(pix_rgb), .test_mode(test_mode),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .busy(busy), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DEN(LCD_DEN),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
    );

    // Upstream source: pixel value is a function of its coordinates.
    assign pix_rgb = {pix_x[4:0], pix_x[5:0], pix_y[4:0]};

    int cyc;
    always @(posedge clk or negedge nRST) begin
        if (!nRST) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int x, input int y, input logic tm);
        logic [15:0] c;
        c = {x[4:0], x[5:0], y[4:0]};
        if (BAR_EN && tm) begin
            case (x / 64)
                0: c = 16'hFFFF;
                1: c = 16'hFFE0;
                2: c = 16'h07FF;
                3: c = 16'h07E0;
                4: c = 16'hF81F;
                5: c = 16'hF800;
                6: c = 16'h001F;
                default: c = 16'h0000;
            endcase
        end
        return c;
    endfunction

    typedef struct {
        int cyc; int en;
        int busy; int fs; int req; int den; int hs; int vs; int x; int y;
    } vec_t;
    localparam int NV = 17;
    vec_t tbl [NV];

    logic        mon_on;
    logic [15:0] q [$];
    int ex, ey, den_run, den_rise, hs_fall, vs_fall, fs_cyc;
    logic den_p, hs_p, vs_p, fs_valid;

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                q.delete();
                ex = 0; ey = 0; den_run = 0; den_rise = -1; hs_fall = 0; vs_fall = 0; fs_cyc = 0;
                den_p = 1'b0; hs_p = 1'b1; vs_p = 1'b1; fs_valid = 1'b0;
            end else begin
                if (pix_req) begin
                    chk("pix_x", pix_x, ex);
                    chk("pix_y", pix_y, ey);
                    chk("frame_start_at_origin", frame_start, (ex == 0 && ey == 0));
                    q.push_back(exp_pix(ex, ey, test_mode));
                    ex++;
                    if (ex == HA) begin
                        ex = 0;
                        ey = (ey == VA - 1) ? 0 : ey + 1;
                    end
                end else begin
                    chk("xy_idle", {pix_x, pix_y}, 0);
                    chk("frame_start_idle", frame_start, 0);
                end
                if (frame_start) begin
                    if (fs_valid) chk("frame_period", cyc - fs_cyc, FP);
                    fs_valid = 1'b1;
                    fs_cyc   = cyc;
                end
                if (LCD_DEN) begin
                    if (q.size() == 0) chk("sb_underflow", 1, 0);
                    else               chk("rgb", {LCD_R, LCD_G, LCD_B}, q.pop_front());
                    if (!den_p) den_rise = cyc;
                    den_run++;
                end else begin
                    chk("rgb_blank", {LCD_R, LCD_G, LCD_B}, 0);
                    if (den_p) begin
                        chk("den_len", den_run, HA);
                        den_run = 0;
                    end
                end
                if (!LCD_HSYNC && hs_p) begin
                    hs_fall = cyc;
                    if (den_rise >= 0 && cyc - den_rise < HT) chk("hsync_ofs", cyc - den_rise, HA + HF);
                end
                if (LCD_HSYNC && !hs_p) chk("hsync_len", cyc - hs_fall, HS);
                if (!LCD_VSYNC && vs_p) begin
                    vs_fall = cyc;
                    if (fs_valid) chk("vsync_ofs", cyc - fs_cyc, (VA + VF) * HT + 1);
                end
                if (LCD_VSYNC && !vs_p) chk("vsync_len", cyc - vs_fall, VS * HT);
                den_p = LCD_DEN;
                hs_p  = LCD_HSYNC;
                vs_p  = LCD_VSYNC;
            end
        end
    endtask

    task automatic wait_fs(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        if (k == lim) chk("timeout_frame_start", 0, 1);
    endtask

    task automatic wait_req(input int x, input int y, input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(negedge clk);
            if (pix_req && pix_x == 9'(x) && pix_y == 9'(y)) break;
        end
        if (k == lim) chk("timeout_pix_req", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, act;
        nRST = 1'b0; en = 1'b0; test_mode = 1'b0; mon_on = 1'b0;

        //          cyc  en bsy fs req den hs vs  x   y
        tbl[0]  = '{  0, 0, 0, 0, 0, 0, 1, 1,   0, 0};
        tbl[1]  = '{  5, 0, 0, 0, 0, 0, 1, 1,   0, 0};
        tbl[2]  = '{  9, 0, 0, 0, 0, 0, 1, 1,   0, 0};
        tbl[3]  = '{ 10, 1, 0, 0, 0, 0, 1, 1,   0, 0};
        tbl[4]  = '{ 11, 1, 1, 0, 0, 0, 1, 1,   0, 0};
        tbl[5]  = '{ 12, 1, 1, 1, 1, 0, 1, 1,   0, 0};
        tbl[6]  = '{ 13, 1, 1, 0, 1, 1, 1, 1,   1, 0};
        tbl[7]  = '{ 14, 1, 1, 0, 1, 1, 1, 1,   2, 0};
        tbl[8]  = '{491, 1, 1, 0, 1, 1, 1, 1, 479, 0};
        tbl[9]  = '{492, 1, 1, 0, 0, 1, 1, 1,   0, 0};
        tbl[10] = '{493, 1, 1, 0, 0, 0, 1, 1,   0, 0};
        tbl[11] = '{500, 1, 1, 0, 0, 0, 1, 1,   0, 0};
        tbl[12] = '{501, 1, 1, 0, 0, 0, 0, 1,   0, 0};
        tbl[13] = '{504, 1, 1, 0, 0, 0, 0, 1,   0, 0};
        tbl[14] = '{505, 1, 1, 0, 0, 0, 1, 1,   0, 0};
        tbl[15] = '{543, 1, 1, 0, 1, 0, 1, 1,   0, 1};
        tbl[16] = '{544, 1, 1, 0, 1, 1, 1, 1,   1, 1};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        nRST   = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < NV; i++) begin
            while (cyc != tbl[i].cyc) @(negedge clk);
            chk("t_busy",  busy,        tbl[i].busy);
            chk("t_fs",    frame_start, tbl[i].fs);
            chk("t_req",   pix_req,     tbl[i].req);
            chk("t_den",   LCD_DEN,     tbl[i].den);
            chk("t_hsync", LCD_HSYNC,   tbl[i].hs);
            chk("t_vsync", LCD_VSYNC,   tbl[i].vs);
            chk("t_x",     pix_x,       tbl[i].x);
            chk("t_y",     pix_y,       tbl[i].y);
            en = tbl[i].en[0];
        end

        // Two more frames in RUN, then drain with a re-enable inside DRAIN.
        wait_fs(2 * FP);
        wait_fs(2 * FP);
        wait_req(0, 2, 2 * FP);
        en = 1'b0;
        repeat (200) @(negedge clk);
        en = 1'b1;
        wait_fs(2 * FP);
        wait_req(0, 2, 2 * FP);
        en = 1'b0;
        begin
            int k;
            for (k = 0; k < 2 * FP; k++) begin
                @(negedge clk);
                if (!busy) break;
            end
            if (k == 2 * FP) chk("timeout_busy_fall", 0, 1);
        end
        chk("busy_fall_at_frame_end", cyc, fs_cyc + FP - 1);
        act = 0;
        repeat (3 * HT) begin
            @(negedge clk);
            act += int'(pix_req) + int'(LCD_DEN) + int'(busy);
        end
        chk("activity_after_drain", act, 0);
        chk("sb_empty_after_drain", q.size(), 0);
        chk("scan_completed_frame", ex + ey, 0);

        // Restart, then asynchronous reset in the middle of an active line.
        mon_on = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        en = 1'b1;
        e  = cyc;
        wait_fs(4 * HT);
        chk("restart_fs_latency", cyc - e, 2);
        wait_req(100, 1, 4 * HT);
        mon_on = 1'b0;
        #1 nRST = 1'b0;
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_req",   pix_req, 0);
        chk("rst_fs",    frame_start, 0);
        chk("rst_den",   LCD_DEN, 0);
        chk("rst_xy",    {pix_x, pix_y}, 0);
        chk("rst_rgb",   {LCD_R, LCD_G, LCD_B}, 0);
        chk("rst_hsync", LCD_HSYNC, 1);
        chk("rst_vsync", LCD_VSYNC, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
`ifdef LCD_TESTPAT_EN
        test_mode = 1'b1;
`endif
        repeat (2) @(negedge clk);
        mon_on = 1'b1;
        en = 1'b1;
        e  = cyc;
        wait_fs(4 * HT);
        chk("reset_restart_fs_latency", cyc - e, 2);
        repeat (3 * HT) @(negedge clk);
        chk("restart_scan_row", ey, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
